// File: rtl/hazard_pipe_ctrl.sv
// Hazard control for the ID/EX, EX/MEM and MEM/WB stages: stall/flush strobes, forwarding and
// memory-wait FSM. Define HAZ_PERF_CNT_EN to add stall/flush performance counters.
module hazard_pipe_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CTRL_W = 13,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CTRL_W-1:0] i_id_ctrl,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic [REG_AW-1:0] i_id_rd,
  input  logic              i_ex_taken,
  input  logic              i_mem_ready,
  output logic              o_flush,
  output logic              o_pc_stall,
  output logic              o_ifid_stall,
  output logic              o_ifid_flush,
  output logic [CTRL_W-1:0] o_ex_ctrl,
  output logic [3:0]        o_mem_ctrl,
  output logic [1:0]        o_wb_ctrl,
  output logic [REG_AW-1:0] o_ex_rd,
  output logic [REG_AW-1:0] o_mem_rd,
  output logic [REG_AW-1:0] o_wb_rd,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b,
  output logic              o_mem_wait
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
`endif
);

  localparam logic [CTRL_W-1:0] Bubble = CTRL_W'(13'h0005);

  typedef enum logic {StRun, StMemWait} state_e;

  state_e            r_state;
  logic [CTRL_W-1:0] r_ex_ctrl;
  logic [3:0]        r_mem_ctrl;
  logic [1:0]        r_wb_ctrl;
  logic [REG_AW-1:0] r_ex_rd, r_ex_rs1, r_ex_rs2, r_mem_rd, r_wb_rd;

  logic w_use_rs1, w_use_rs2, w_mem_busy, w_load_use, w_bubble;

  // Bundle: {alu_src1[12:11], alu_src2[10:9], mem_to_reg, reg_write, mem_read, mem_write,
  //          branch, branch_base, alu_op[2:0]}
  assign w_use_rs1  = (i_id_ctrl[12:11] == 2'b00) | i_id_ctrl[3];
  assign w_use_rs2  = (i_id_ctrl[10:9] == 2'b00) | i_id_ctrl[5];
  assign w_mem_busy = (r_mem_ctrl[1] | r_mem_ctrl[0]) & ~i_mem_ready;
  assign w_load_use = r_ex_ctrl[6] & (r_ex_rd != '0) &
                      ((w_use_rs1 & (r_ex_rd == i_id_rs1)) |
                       (w_use_rs2 & (r_ex_rd == i_id_rs2)));
  assign w_bubble   = i_ex_taken | w_load_use;

  // A pending memory access outranks everything; a taken branch outranks load-use.
  assign o_pc_stall   = w_mem_busy | (~i_ex_taken & w_load_use);
  assign o_ifid_stall = o_pc_stall;
  assign o_flush      = ~w_mem_busy & w_bubble;
  assign o_ifid_flush = ~w_mem_busy & i_ex_taken;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic              mem_wr,
                                         input logic [REG_AW-1:0] mem_rd,
                                         input logic              wb_wr,
                                         input logic [REG_AW-1:0] wb_rd);
    if (mem_wr && (mem_rd != '0) && (mem_rd == rs)) return 2'b10;
    if (wb_wr && (wb_rd != '0) && (wb_rd == rs))    return 2'b01;
    return 2'b00;
  endfunction

  assign o_fwd_a = fwd_sel(r_ex_rs1, r_mem_ctrl[2], r_mem_rd, r_wb_ctrl[0], r_wb_rd);
  assign o_fwd_b = fwd_sel(r_ex_rs2, r_mem_ctrl[2], r_mem_rd, r_wb_ctrl[0], r_wb_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_ctrl  <= Bubble;
      r_ex_rd    <= '0;
      r_ex_rs1   <= '0;
      r_ex_rs2   <= '0;
      r_mem_ctrl <= '0;
      r_mem_rd   <= '0;
      r_wb_ctrl  <= '0;
      r_wb_rd    <= '0;
    end else if (!w_mem_busy) begin
      r_wb_ctrl  <= r_mem_ctrl[3:2];
      r_wb_rd    <= r_mem_rd;
      r_mem_ctrl <= r_ex_ctrl[8:5];
      r_mem_rd   <= r_ex_rd;
      // Bubbles carry zero register indices so they never match hazard or forwarding compares.
      if (w_bubble) begin
        r_ex_ctrl <= Bubble;
        r_ex_rd   <= '0;
        r_ex_rs1  <= '0;
        r_ex_rs2  <= '0;
      end else begin
        r_ex_ctrl <= i_id_ctrl;
        r_ex_rd   <= i_id_rd;
        r_ex_rs1  <= i_id_rs1;
        r_ex_rs2  <= i_id_rs2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StRun;
    end else begin
      unique case (r_state)
        StRun:     if (w_mem_busy) r_state <= StMemWait;
        StMemWait: if (i_mem_ready) r_state <= StRun;
        default:   r_state <= StRun;
      endcase
    end
  end

  assign o_ex_ctrl  = r_ex_ctrl;
  assign o_mem_ctrl = r_mem_ctrl;
  assign o_wb_ctrl  = r_wb_ctrl;
  assign o_ex_rd    = r_ex_rd;
  assign o_mem_rd   = r_mem_rd;
  assign o_wb_rd    = r_wb_rd;
  assign o_mem_wait = (r_state == StMemWait);

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (o_pc_stall)   r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (o_ifid_flush) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Directed bench for hazard_pipe_ctrl: each step drives ID inputs, queues the expected
// outputs for that cycle and compares them mid-cycle. Honours HAZ_PERF_CNT_EN.
module tb_hazard_pipe_ctrl;

  localparam logic [12:0] C_BUB  = 13'h0005;
  localparam logic [12:0] C_RT   = 13'h0084;  // R-type ALU op
  localparam logic [12:0] C_LD   = 13'h03C0;  // load
  localparam logic [12:0] C_JAL  = 13'h0C90;  // PC-relative jump, reads no registers
  localparam logic [12:0] C_ADDI = 13'h0280;  // ALU with immediate, reads rs1 only
  localparam logic [12:0] C_ST   = 13'h0220;  // store, reads rs1 and rs2

  // {flush, pc_stall, ifid_stall, ifid_flush, mem_wait}
  localparam logic [4:0] S_NONE = 5'b00000;
  localparam logic [4:0] S_LU   = 5'b11100;
  localparam logic [4:0] S_TK   = 5'b10010;
  localparam logic [4:0] S_W0   = 5'b01100;
  localparam logic [4:0] S_W1   = 5'b01101;
  localparam logic [4:0] S_WTK  = 5'b10011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [12:0] id_ctrl;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        ex_taken, mem_ready;
  logic        flush, pc_stall, ifid_stall, ifid_flush, mem_wait;
  logic [12:0] ex_ctrl;
  logic [3:0]  mem_ctrl;
  logic [1:0]  wb_ctrl, fwd_a, fwd_b;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  hazard_pipe_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_id_ctrl    (id_ctrl),
    .i_id_rs1     (id_rs1),
    .i_id_rs2     (id_rs2),
    .i_id_rd      (id_rd),
    .i_ex_taken   (ex_taken),
    .i_mem_ready  (mem_ready),
    .o_flush      (flush),
    .o_pc_stall   (pc_stall),
    .o_ifid_stall (ifid_stall),
    .o_ifid_flush (ifid_flush),
    .o_ex_ctrl    (ex_ctrl),
    .o_mem_ctrl   (mem_ctrl),
    .o_wb_ctrl    (wb_ctrl),
    .o_ex_rd      (ex_rd),
    .o_mem_rd     (mem_rd),
    .o_wb_rd      (wb_rd),
    .o_fwd_a      (fwd_a),
    .o_fwd_b      (fwd_b),
    .o_mem_wait   (mem_wait)
`ifdef HAZ_PERF_CNT_EN
    ,
    .o_stall_cnt  (stall_cnt),
    .o_flush_cnt  (flush_cnt)
`endif
  );

  typedef struct {
    int          id;
    logic [4:0]  strb;
    logic [12:0] ex_ctrl;
    logic [3:0]  mem_ctrl;
    logic [1:0]  wb_ctrl;
    logic [14:0] rds;
    logic [3:0]  fwd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  int   step_id = 0;

  task automatic chk(input string tag, input int id, input logic [31:0] got,
                     input logic [31:0] want);
    n_checks++;
    assert (got === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s step %0d: got %h expected %h", tag, id, got, want);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("queue_empty", step_id, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk("strobes", e.id, 32'({flush, pc_stall, ifid_stall, ifid_flush, mem_wait}), 32'(e.strb));
    chk("ex_ctrl", e.id, 32'(ex_ctrl), 32'(e.ex_ctrl));
    chk("mem_ctrl", e.id, 32'(mem_ctrl), 32'(e.mem_ctrl));
    chk("wb_ctrl", e.id, 32'(wb_ctrl), 32'(e.wb_ctrl));
    chk("rd_ex_mem_wb", e.id, 32'({ex_rd, mem_rd, wb_rd}), 32'(e.rds));
    chk("fwd_ab", e.id, 32'({fwd_a, fwd_b}), 32'(e.fwd));
  endtask

  // Called at a falling edge: drive, queue expectation, sample 1 ns later, run to next fall.
  task automatic step(input logic [12:0] c, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [4:0] d, input logic tk, input logic rdy,
                      input logic [4:0] e_strb, input logic [12:0] e_ex,
                      input logic [3:0] e_mem, input logic [1:0] e_wb,
                      input logic [4:0] e_exrd, input logic [4:0] e_memrd,
                      input logic [4:0] e_wbrd, input logic [1:0] e_fa, input logic [1:0] e_fb);
    exp_t e;
    id_ctrl   = c;
    id_rs1    = s1;
    id_rs2    = s2;
    id_rd     = d;
    ex_taken  = tk;
    mem_ready = rdy;
    e.id       = step_id;
    e.strb     = e_strb;
    e.ex_ctrl  = e_ex;
    e.mem_ctrl = e_mem;
    e.wb_ctrl  = e_wb;
    e.rds      = {e_exrd, e_memrd, e_wbrd};
    e.fwd      = {e_fa, e_fb};
    exp_q.push_back(e);
    #1;
    compare_out();
    step_id++;
    @(negedge clk);
  endtask

  initial begin
    id_ctrl = C_RT; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3;
    ex_taken = 1'b0; mem_ready = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    // Reset held for three rising edges
    repeat (3) step(C_RT, 1, 2, 3, 0, 1, S_NONE, C_BUB, 4'h0, 2'b00, 0, 0, 0, 2'b00, 2'b00);
    rst_n = 1'b1;
    //   ctrl    rs1 rs2 rd tk rdy strobes ex_ctrl  mem       wb     exrd mrd wrd fa     fb
    step(C_RT,   1,  2,  3, 0, 1, S_NONE, C_BUB,  4'b0000, 2'b00, 0,  0,  0,  2'b00, 2'b00);
    step(C_LD,   1,  0,  5, 0, 1, S_NONE, C_RT,   4'b0000, 2'b00, 3,  0,  0,  2'b00, 2'b00);
    step(C_RT,   5,  1,  6, 0, 1, S_LU,   C_LD,   4'b0100, 2'b00, 5,  3,  0,  2'b00, 2'b00);
    step(C_RT,   5,  1,  6, 0, 1, S_NONE, C_BUB,  4'b1110, 2'b01, 0,  5,  3,  2'b00, 2'b00);
    step(C_JAL,  0,  0,  1, 0, 1, S_NONE, C_RT,   4'b0000, 2'b11, 6,  0,  5,  2'b01, 2'b00);
    step(C_RT,   2,  3,  7, 1, 1, S_TK,   C_JAL,  4'b0100, 2'b00, 1,  6,  0,  2'b00, 2'b00);
    step(C_RT,   6,  1,  7, 0, 1, S_NONE, C_BUB,  4'b0100, 2'b01, 0,  1,  6,  2'b00, 2'b00);
    step(C_LD,   7,  0,  8, 0, 1, S_NONE, C_RT,   4'b0000, 2'b01, 7,  0,  1,  2'b00, 2'b01);
    step(C_ADDI, 2,  0,  9, 0, 1, S_NONE, C_LD,   4'b0100, 2'b00, 8,  7,  0,  2'b10, 2'b00);
    // Load in MEM waits three cycles; a taken branch in EX is ignored until memory completes
    step(C_RT,   9,  8, 10, 0, 0, S_W0,   C_ADDI, 4'b1110, 2'b01, 9,  8,  7,  2'b00, 2'b00);
    step(C_RT,   9,  8, 10, 1, 0, S_W1,   C_ADDI, 4'b1110, 2'b01, 9,  8,  7,  2'b00, 2'b00);
    step(C_RT,   9,  8, 10, 1, 0, S_W1,   C_ADDI, 4'b1110, 2'b01, 9,  8,  7,  2'b00, 2'b00);
    step(C_RT,   9,  8, 10, 1, 1, S_WTK,  C_ADDI, 4'b1110, 2'b01, 9,  8,  7,  2'b00, 2'b00);
    step(C_ADDI, 1,  0,  7, 0, 1, S_NONE, C_BUB,  4'b0100, 2'b11, 0,  9,  8,  2'b00, 2'b00);
    step(C_ADDI, 2,  0,  7, 0, 1, S_NONE, C_ADDI, 4'b0000, 2'b01, 7,  0,  9,  2'b00, 2'b00);
    step(C_RT,   7,  0, 10, 0, 1, S_NONE, C_ADDI, 4'b0100, 2'b00, 7,  7,  0,  2'b00, 2'b00);
    // x7 written by both MEM and WB: MEM wins
    step(C_ADDI, 3,  0,  0, 0, 1, S_NONE, C_RT,   4'b0100, 2'b01, 10, 7,  7,  2'b10, 2'b00);
    step(C_RT,   0,  3, 11, 0, 1, S_NONE, C_ADDI, 4'b0100, 2'b01, 0,  10, 7,  2'b00, 2'b00);
    // x0 writer in MEM, x0 reader in EX: no forwarding
    step(C_BUB,  0,  0,  0, 0, 1, S_NONE, C_RT,   4'b0100, 2'b01, 11, 0,  10, 2'b00, 2'b00);
    step(C_LD,   1,  0,  0, 0, 1, S_NONE, C_BUB,  4'b0100, 2'b01, 0,  11, 0,  2'b00, 2'b00);
    // Load to x0 followed by x0 reader: no stall
    step(C_RT,   0,  0, 12, 0, 1, S_NONE, C_LD,   4'b0000, 2'b01, 0,  0,  11, 2'b00, 2'b00);
    step(C_LD,   2,  0, 13, 0, 1, S_NONE, C_RT,   4'b1110, 2'b00, 12, 0,  0,  2'b00, 2'b00);
    // Load-use through rs2 of a store
    step(C_ST,   4, 13,  0, 0, 1, S_LU,   C_LD,   4'b0100, 2'b11, 13, 12, 0,  2'b00, 2'b00);
    step(C_ST,   4, 13,  0, 0, 1, S_NONE, C_BUB,  4'b1110, 2'b01, 0,  13, 12, 2'b00, 2'b00);
    step(C_BUB,  0,  0,  0, 0, 1, S_NONE, C_ST,   4'b0000, 2'b11, 0,  0,  13, 2'b00, 2'b01);
`ifdef HAZ_PERF_CNT_EN
    chk("stall_cnt", step_id, stall_cnt, 32'd5);
    chk("flush_cnt", step_id, flush_cnt, 32'd2);
`endif
    // Asynchronous reset takes effect with no clock edge
    rst_n = 1'b0;
    step(C_BUB, 0, 0, 0, 0, 1, S_NONE, C_BUB, 4'b0000, 2'b00, 0, 0, 0, 2'b00, 2'b00);
`ifdef HAZ_PERF_CNT_EN
    chk("stall_cnt_rst", step_id, stall_cnt, 32'd0);
    chk("flush_cnt_rst", step_id, flush_cnt, 32'd0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
